vending_machine_minor: RTL and testbench



---
 rtl/vending_machine_minor_pkg.sv | 49 ++++
 rtl/vm_price_lut.sv | 33 +++
 rtl/vending_machine_minor.sv | 131 +++++++++++++
 tb/tb_vending_machine_minor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vending_machine_minor_pkg.sv
// Shared definitions for the vending_machine_minor controller:
// widths, product select codes, default prices, accepted coin values,
// the FSM state type and small arithmetic helpers.
package vending_machine_minor_pkg;

    localparam int unsigned MONEY_W = 7;
    localparam int unsigned TOTAL_W = 8;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned NPROD   = 5;

    // Product select codes; 5..31 are invalid selections
    localparam logic [SEL_W-1:0] SEL_WRAPPERS = 5'd0;
    localparam logic [SEL_W-1:0] SEL_BOTTLES  = 5'd1;
    localparam logic [SEL_W-1:0] SEL_PACKETS  = 5'd2;
    localparam logic [SEL_W-1:0] SEL_CANS     = 5'd3;
    localparam logic [SEL_W-1:0] SEL_TUB      = 5'd4;

    // Default prices
    localparam int unsigned DEF_PRICE_WRAPPERS = 15;
    localparam int unsigned DEF_PRICE_BOTTLES  = 20;
    localparam int unsigned DEF_PRICE_PACKETS  = 30;
    localparam int unsigned DEF_PRICE_CANS     = 40;
    localparam int unsigned DEF_PRICE_TUB      = 55;

    // Coin values accepted when coin checking is built in
    localparam logic [MONEY_W-1:0] COIN_0  = 7'd0;
    localparam logic [MONEY_W-1:0] COIN_5  = 7'd5;
    localparam logic [MONEY_W-1:0] COIN_10 = 7'd10;
    localparam logic [MONEY_W-1:0] COIN_20 = 7'd20;
    localparam logic [MONEY_W-1:0] COIN_50 = 7'd50;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_REFUND = 2'd2
    } vm_state_e;

    // True when the value is one of the accepted coin denominations
    function automatic logic coin_ok(input logic [MONEY_W-1:0] c);
        return (c == COIN_0) || (c == COIN_5) || (c == COIN_10) ||
               (c == COIN_20) || (c == COIN_50);
    endfunction

    // Clamp an 8-bit amount onto the 7-bit change output
    function automatic logic [MONEY_W-1:0] sat7(input logic [TOTAL_W-1:0] v);
        return v[TOTAL_W-1] ? 7'd127 : v[MONEY_W-1:0];
    endfunction

endpackage

// File: rtl/vm_price_lut.sv
// Price lookup: maps a product select code to {valid, price}.
// Ports:
//   sel   in  5  product select code
//   valid out 1  high for codes 0..4
//   price out 7  price of the selected product (0 when invalid)
module vm_price_lut
    import vending_machine_minor_pkg::*;
#(
    parameter int unsigned PRICE_WRAPPERS = DEF_PRICE_WRAPPERS,
    parameter int unsigned PRICE_BOTTLES  = DEF_PRICE_BOTTLES,
    parameter int unsigned PRICE_PACKETS  = DEF_PRICE_PACKETS,
    parameter int unsigned PRICE_CANS     = DEF_PRICE_CANS,
    parameter int unsigned PRICE_TUB      = DEF_PRICE_TUB
) (
    input  logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic [MONEY_W-1:0] price
);

    always_comb begin
        valid = 1'b1;
        price = '0;
        case (sel)
            SEL_WRAPPERS: price = 7'(PRICE_WRAPPERS);
            SEL_BOTTLES:  price = 7'(PRICE_BOTTLES);
            SEL_PACKETS:  price = 7'(PRICE_PACKETS);
            SEL_CANS:     price = 7'(PRICE_CANS);
            SEL_TUB:      price = 7'(PRICE_TUB);
            default:      valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/vending_machine_minor.sv
// Single-transaction vending controller for five products.
// A transaction is detected when {money, extramoney, sel} changes and the
// coin total is non-zero; one cycle later the controller either pulses one
// dispense flag with change, or refunds the full total.
// Optional feature: define VM_COIN_CHECK_EN to refund any transaction whose
// coins are not one of 0/5/10/20/50.
// Ports:
//   clock           in  1  rising-edge system clock
//   reset           in  1  synchronous active-high reset
//   money           in  7  primary coin value
//   extramoney      in  7  top-up coin value
//   sel             in  5  product select (0..4 valid)
//   change          out 7  change or refund amount (registered, held)
//   wrappers        out 1  dispense pulse, product 0
//   plasticbottles  out 1  dispense pulse, product 1
//   packets         out 1  dispense pulse, product 2
//   cans            out 1  dispense pulse, product 3
//   plastictub      out 1  dispense pulse, product 4
module vending_machine_minor
    import vending_machine_minor_pkg::*;
#(
    parameter int unsigned PRICE_WRAPPERS = DEF_PRICE_WRAPPERS,
    parameter int unsigned PRICE_BOTTLES  = DEF_PRICE_BOTTLES,
    parameter int unsigned PRICE_PACKETS  = DEF_PRICE_PACKETS,
    parameter int unsigned PRICE_CANS     = DEF_PRICE_CANS,
    parameter int unsigned PRICE_TUB      = DEF_PRICE_TUB
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [MONEY_W-1:0] money,
    input  logic [MONEY_W-1:0] extramoney,
    input  logic [SEL_W-1:0]   sel,
    output logic [MONEY_W-1:0] change,
    output logic               wrappers,
    output logic               plasticbottles,
    output logic               packets,
    output logic               cans,
    output logic               plastictub
);

    localparam int unsigned TUPLE_W = 2 * MONEY_W + SEL_W;

    vm_state_e             state;
    logic [TUPLE_W-1:0]    last_tuple;
    logic [MONEY_W-1:0]    pend_change;
    logic [NPROD-1:0]      pend_flags;
    logic [MONEY_W-1:0]    change_r;
    logic [NPROD-1:0]      flags_r;

    logic                  lut_valid;
    logic [MONEY_W-1:0]    lut_price;
    logic [TOTAL_W-1:0]    total_c;
    logic [TUPLE_W-1:0]    tuple_c;
    logic                  coins_ok_c;
    logic                  trigger_c;
    logic                  vend_ok_c;

    vm_price_lut #(
        .PRICE_WRAPPERS (PRICE_WRAPPERS),
        .PRICE_BOTTLES  (PRICE_BOTTLES),
        .PRICE_PACKETS  (PRICE_PACKETS),
        .PRICE_CANS     (PRICE_CANS),
        .PRICE_TUB      (PRICE_TUB)
    ) u_price_lut (
        .sel   (sel),
        .valid (lut_valid),
        .price (lut_price)
    );

`ifdef VM_COIN_CHECK_EN
    assign coins_ok_c = coin_ok(money) && coin_ok(extramoney);
`else
    assign coins_ok_c = 1'b1;
`endif

    // Transaction detection and vend/refund decision for the current inputs
    always_comb begin
        total_c   = TOTAL_W'(money) + TOTAL_W'(extramoney);
        tuple_c   = {money, extramoney, sel};
        trigger_c = (tuple_c != last_tuple) && (total_c != '0);
        vend_ok_c = lut_valid && coins_ok_c && (total_c >= TOTAL_W'(lut_price));
    end

    // FSM: the detecting edge latches the result, the next edge presents it
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_tuple  <= '0;
            pend_change <= '0;
            pend_flags  <= '0;
            change_r    <= '0;
            flags_r     <= '0;
        end else begin
            last_tuple <= tuple_c;

            case (state)
                ST_VEND: begin
                    flags_r  <= pend_flags;
                    change_r <= pend_change;
                end
                ST_REFUND: begin
                    flags_r  <= '0;
                    change_r <= pend_change;
                end
                default: flags_r <= '0;
            endcase

            if (trigger_c) begin
                if (vend_ok_c) begin
                    state       <= ST_VEND;
                    pend_flags  <= NPROD'(1) << sel[2:0];
                    pend_change <= sat7(total_c - TOTAL_W'(lut_price));
                end else begin
                    state       <= ST_REFUND;
                    pend_flags  <= '0;
                    pend_change <= sat7(total_c);
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    assign change         = change_r;
    assign wrappers       = flags_r[0];
    assign plasticbottles = flags_r[1];
    assign packets        = flags_r[2];
    assign cans           = flags_r[3];
    assign plastictub     = flags_r[4];

endmodule

// File: tb/tb_vending_machine_minor.sv
// Self-checking bench for vending_machine_minor: directed steps from the
// test plan followed by randomized coin/select traffic, all compared
// against a transaction-level reference model.
module tb_vending_machine_minor;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] money;
    logic [6:0] extramoney;
    logic [4:0] sel;
    logic [6:0] change;
    logic       wrappers, plasticbottles, packets, cans, plastictub;
    logic [4:0] flags;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          prices [5] = '{15, 20, 30, 40, 55};
    logic [18:0] m_last;
    bit          m_pend_valid;
    int          m_pend_flags, m_pend_change;
    int          m_exp_flags, m_exp_change;

    vending_machine_minor dut (
        .clock          (clock),
        .reset          (reset),
        .money          (money),
        .extramoney     (extramoney),
        .sel            (sel),
        .change         (change),
        .wrappers       (wrappers),
        .plasticbottles (plasticbottles),
        .packets        (packets),
        .cans           (cans),
        .plastictub     (plastictub)
    );

    always #5 clock = ~clock;

    assign flags = {plastictub, cans, packets, plasticbottles, wrappers};

    function automatic bit is_coin(input int c);
        return (c == 0) || (c == 5) || (c == 10) || (c == 20) || (c == 50);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        int  t;
        bit  ok;
        if (reset) begin
            m_exp_flags  = 0;
            m_exp_change = 0;
            m_pend_valid = 0;
            m_last       = '0;
        end else begin
            m_exp_flags = m_pend_valid ? m_pend_flags : 0;
            if (m_pend_valid) m_exp_change = m_pend_change;
            t = int'(money) + int'(extramoney);
            if ({money, extramoney, sel} != m_last && t != 0) begin
                ok = 0;
                if (int'(sel) < 5) ok = (t >= prices[int'(sel)]);
`ifdef VM_COIN_CHECK_EN
                if (!is_coin(int'(money)) || !is_coin(int'(extramoney))) ok = 0;
`endif
                if (ok) begin
                    m_pend_flags  = 1 << int'(sel);
                    m_pend_change = (t - prices[int'(sel)] > 127) ? 127 : t - prices[int'(sel)];
                end else begin
                    m_pend_flags  = 0;
                    m_pend_change = (t > 127) ? 127 : t;
                end
                m_pend_valid = 1;
            end else begin
                m_pend_valid = 0;
            end
            m_last = {money, extramoney, sel};
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model
    task automatic step(input int m, input int e, input int s, input bit r);
        money      = 7'(m);
        extramoney = 7'(e);
        sel        = 5'(s);
        reset      = r;
        @(posedge clock);
        model_edge();
        #1;
        check("flags", int'(flags), m_exp_flags);
        check("change", int'(change), m_exp_change);
        check("onehot", int'($countones(flags) <= 1), 1);
    endtask

    initial begin
        money = '0; extramoney = '0; sel = '0; reset = 1'b1;
        m_last = '0; m_pend_valid = 0; m_pend_flags = 0; m_pend_change = 0;
        m_exp_flags = 0; m_exp_change = 0;

        // Reset held
        step(0, 0, 0, 1);
        step(5, 10, 0, 1);
        check("reset_change", int'(change), 0);
        check("reset_flags", int'(flags), 0);

        // Exact payment for wrappers, single pulse while held
        step(5, 10, 0, 0);
        check("wrap_latency", int'(flags), 0);
        step(5, 10, 0, 0);
        check("wrap_pulse", int'(flags), 1);
        check("wrap_change", int'(change), 0);
        step(5, 10, 0, 0);
        check("wrap_single", int'(flags), 0);
        step(5, 10, 0, 0);

        // Tub with change
        step(50, 50, 4, 0);
        step(50, 50, 4, 0);
        check("tub_pulse", int'(flags), 16);
        check("tub_change", int'(change), 45);

        // Underpayment refund
        step(5, 20, 2, 0);
        step(5, 20, 2, 0);
        check("under_flags", int'(flags), 0);
        check("under_change", int'(change), 25);

        // Invalid select refund, then same coins on cans back-to-back
        step(20, 50, 5, 0);
        step(20, 50, 3, 0);
        check("inv_change", int'(change), 70);
        check("inv_flags", int'(flags), 0);
        step(20, 50, 3, 0);
        check("cans_pulse", int'(flags), 8);
        check("cans_change", int'(change), 30);

        // Non-standard coin
        step(7, 10, 0, 0);
        step(7, 10, 0, 0);
`ifdef VM_COIN_CHECK_EN
        check("coin_refund_flags", int'(flags), 0);
        check("coin_refund_change", int'(change), 17);
`else
        check("coin_accept_flags", int'(flags), 1);
        check("coin_accept_change", int'(change), 2);
`endif

        // Saturated change
        step(127, 127, 0, 0);
        step(127, 127, 0, 0);
        check("sat_change", int'(change), 127);

        // Reset mid-transaction with inputs held
        step(10, 10, 1, 0);
        step(10, 10, 1, 1);
        check("midrst_change", int'(change), 0);
        check("midrst_flags", int'(flags), 0);
        step(10, 10, 1, 1);
        step(10, 10, 1, 0);
        check("post_rst_latency", int'(flags), 0);
        step(10, 10, 1, 0);
        check("post_rst_pulse", int'(flags), 2);
        check("post_rst_change", int'(change), 0);
        step(10, 10, 1, 0);
        check("post_rst_single", int'(flags), 0);

        // Randomized traffic
        begin
            int coins [5] = '{0, 5, 10, 20, 50};
            int m = 0, e = 0, s = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : coins[$urandom_range(0, 4)];
                    e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : coins[$urandom_range(0, 4)];
                    s = int'($urandom_range(0, 6));
                end
                step(m, e, s, $urandom_range(0, 39) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
